// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache controller.
//   state_t       : FSM state encoding (4 bits)
//   is_mem_wait() : true in the states that hold a RAM request open
package cache_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOOKUP   = 4'd1,
        ST_WB       = 4'd2,
        ST_FILL     = 4'd3,
        ST_UPDATE   = 4'd4,
        ST_WRCACHE  = 4'd5,
        ST_WT       = 4'd6,
        ST_DONE     = 4'd7,
        ST_DONE_ERR = 4'd8
    } state_t;

    function automatic logic is_mem_wait(input state_t s);
        return (s == ST_WB) || (s == ST_FILL) || (s == ST_WT);
    endfunction

endpackage

// File: rtl/cache_ctrl_wait_timer.sv
// Per-access RAM wait timer.
// Counts cycles spent waiting for mem_ack and flags the last allowed cycle.
//   i_clock   : clock, rising edge
//   i_reset   : asynchronous, active-high
//   i_clear   : restart the count at 0 (takes priority over i_enable)
//   i_enable  : a RAM request is outstanding this cycle
//   o_expired : this is the MEM_TIMEOUT-th waiting cycle; never set when MEM_TIMEOUT=0
module cache_ctrl_wait_timer #(
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam bit              LP_ACTIVE = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] LP_LAST   = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LP_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The count reads 0 on the first waiting cycle, so LP_LAST marks the
    // MEM_TIMEOUT-th one.
    assign o_expired = LP_ACTIVE && i_enable && (r_count == LP_LAST);

endmodule

// File: rtl/cache_ctrl.sv
// Cache controller FSM between the CPU load/store port and main RAM.
// Sequences lookup, dirty-victim writeback, line fill, cache write and
// write-through; keeps saturating hit/miss counters. Datapath lives outside.
//   i_clock, i_reset      : clock (rising edge), asynchronous active-high reset
//   i_read, i_write       : CPU request, sampled in IDLE only (read wins)
//   i_hit, i_dirty        : tag compare result / victim dirty bit, used in LOOKUP
//   i_mem_ack             : RAM access complete pulse
//   i_stats_clr           : synchronous clear of the statistic counters
//   o_ready, o_error      : access complete pulse; error marks a RAM timeout
//   o_busy                : not IDLE
//   o_update_tag, o_fill_we, o_cache_we, o_set_dirty, o_clr_dirty : array controls
//   o_mem_read, o_mem_write, o_mem_victim                         : RAM request
//   o_hit_cnt, o_miss_cnt : saturating lookup statistics
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for a CPU request
// ST_LOOKUP   | tag compare result valid; choose hit / miss path
// ST_WB       | writing dirty victim line to RAM
// ST_FILL     | reading the missing line from RAM
// ST_UPDATE   | write fill data, tag and valid; clear dirty
// ST_WRCACHE  | write CPU store data into the line
// ST_WT       | writing the store through to RAM
// ST_DONE     | access complete
// ST_DONE_ERR | access abandoned after a RAM timeout
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter bit WRITE_BACK     = 1'b1,
    parameter bit WRITE_ALLOCATE = 1'b1,
    parameter int MEM_TIMEOUT    = 255,
    parameter int TO_W           = 8,
    parameter int CNT_W          = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_read,
    input  logic             i_write,
    input  logic             i_hit,
    input  logic             i_dirty,
    input  logic             i_mem_ack,
    input  logic             i_stats_clr,
    output logic             o_ready,
    output logic             o_error,
    output logic             o_busy,
    output logic             o_update_tag,
    output logic             o_fill_we,
    output logic             o_cache_we,
    output logic             o_set_dirty,
    output logic             o_clr_dirty,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_mem_victim,
    output logic [CNT_W-1:0] o_hit_cnt,
    output logic [CNT_W-1:0] o_miss_cnt
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    logic             r_op_wr;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             w_waiting;
    logic             w_expired;

    assign w_waiting = is_mem_wait(r_state);

    // An ack leaves the wait state, so clearing on it also restarts the
    // count for a following wait state (WB -> FILL).
    cache_ctrl_wait_timer #(
        .TO_W        (TO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (!w_waiting || i_mem_ack),
        .i_enable  (w_waiting),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_op_wr <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && (i_read || i_write)) begin
                r_op_wr <= !i_read;
            end
        end
    end

    // Ack is tested before expiry so a same-cycle ack completes normally.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_read || i_write) w_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (i_hit) begin
                    w_next = r_op_wr ? ST_WRCACHE : ST_DONE;
                end else if (!r_op_wr || WRITE_ALLOCATE) begin
                    w_next = (WRITE_BACK && i_dirty) ? ST_WB : ST_FILL;
                end else begin
                    w_next = ST_WT;
                end
            end
            ST_WB: begin
                if (i_mem_ack)      w_next = ST_FILL;
                else if (w_expired) w_next = ST_DONE_ERR;
            end
            ST_FILL: begin
                if (i_mem_ack)      w_next = ST_UPDATE;
                else if (w_expired) w_next = ST_DONE_ERR;
            end
            ST_UPDATE: begin
                w_next = r_op_wr ? ST_WRCACHE : ST_DONE;
            end
            ST_WRCACHE: begin
                w_next = WRITE_BACK ? ST_DONE : ST_WT;
            end
            ST_WT: begin
                if (i_mem_ack)      w_next = ST_DONE;
                else if (w_expired) w_next = ST_DONE_ERR;
            end
            ST_DONE, ST_DONE_ERR: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_ready      = 1'b0;
        o_error      = 1'b0;
        o_busy       = (r_state != ST_IDLE);
        o_update_tag = 1'b0;
        o_fill_we    = 1'b0;
        o_cache_we   = 1'b0;
        o_set_dirty  = 1'b0;
        o_clr_dirty  = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_victim = 1'b0;
        case (r_state)
            ST_WB: begin
                o_mem_write  = 1'b1;
                o_mem_victim = 1'b1;
            end
            ST_FILL: begin
                o_mem_read = 1'b1;
            end
            ST_UPDATE: begin
                o_update_tag = 1'b1;
                o_fill_we    = 1'b1;
                o_clr_dirty  = 1'b1;
            end
            ST_WRCACHE: begin
                o_cache_we  = 1'b1;
                o_set_dirty = WRITE_BACK;
            end
            ST_WT: begin
                o_mem_write = 1'b1;
            end
            ST_DONE: begin
                o_ready = 1'b1;
            end
            ST_DONE_ERR: begin
                o_ready = 1'b1;
                o_error = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (i_stats_clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if (i_hit) begin
                if (r_hit_cnt != LP_CNT_MAX) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
                if (r_miss_cnt != LP_CNT_MAX) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl. Instance A: write-back, write-allocate, timeout 255.
// Instance B: write-through, no write-allocate, timeout 4. Each access is
// expanded into a per-cycle list of expected outputs from the protocol rules;
// a driver replays it and one compare process checks every cycle.
module tb_cache_ctrl;

    localparam int CNT_MAX = 7;

    typedef struct packed {
        logic ready, error, busy, update_tag, fill_we, cache_we,
              set_dirty, clr_dirty, mem_read, mem_write, mem_victim;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    rd, wr, h, d, ack, clr;
        int    hc, mc;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, reset_b;
    logic rd_a, wr_a, hit_a, dirty_a, ack_a, clr_a;
    logic rd_b, wr_b, hit_b, dirty_b, ack_b, clr_b;
    logic o_ready_a, o_error_a, o_busy_a, o_update_tag_a, o_fill_we_a, o_cache_we_a;
    logic o_set_dirty_a, o_clr_dirty_a, o_mem_read_a, o_mem_write_a, o_mem_victim_a;
    logic o_ready_b, o_error_b, o_busy_b, o_update_tag_b, o_fill_we_b, o_cache_we_b;
    logic o_set_dirty_b, o_clr_dirty_b, o_mem_read_b, o_mem_write_b, o_mem_victim_b;
    logic [2:0] hit_cnt_a, miss_cnt_a, hit_cnt_b, miss_cnt_b;

    cache_ctrl #(.WRITE_BACK(1'b1), .WRITE_ALLOCATE(1'b1), .MEM_TIMEOUT(255), .TO_W(8), .CNT_W(3)) u_a (
        .i_clock(clk), .i_reset(reset_a), .i_read(rd_a), .i_write(wr_a), .i_hit(hit_a),
        .i_dirty(dirty_a), .i_mem_ack(ack_a), .i_stats_clr(clr_a),
        .o_ready(o_ready_a), .o_error(o_error_a), .o_busy(o_busy_a), .o_update_tag(o_update_tag_a),
        .o_fill_we(o_fill_we_a), .o_cache_we(o_cache_we_a), .o_set_dirty(o_set_dirty_a),
        .o_clr_dirty(o_clr_dirty_a), .o_mem_read(o_mem_read_a), .o_mem_write(o_mem_write_a),
        .o_mem_victim(o_mem_victim_a), .o_hit_cnt(hit_cnt_a), .o_miss_cnt(miss_cnt_a));

    cache_ctrl #(.WRITE_BACK(1'b0), .WRITE_ALLOCATE(1'b0), .MEM_TIMEOUT(4), .TO_W(3), .CNT_W(3)) u_b (
        .i_clock(clk), .i_reset(reset_b), .i_read(rd_b), .i_write(wr_b), .i_hit(hit_b),
        .i_dirty(dirty_b), .i_mem_ack(ack_b), .i_stats_clr(clr_b),
        .o_ready(o_ready_b), .o_error(o_error_b), .o_busy(o_busy_b), .o_update_tag(o_update_tag_b),
        .o_fill_we(o_fill_we_b), .o_cache_we(o_cache_we_b), .o_set_dirty(o_set_dirty_b),
        .o_clr_dirty(o_clr_dirty_b), .o_mem_read(o_mem_read_b), .o_mem_write(o_mem_write_b),
        .o_mem_victim(o_mem_victim_b), .o_hit_cnt(hit_cnt_b), .o_miss_cnt(miss_cnt_b));

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    rec_t qa[$];
    rec_t qb[$];
    rec_t cur[2];
    int   m_hit[2];
    int   m_miss[2];
    int   req_cyc[2];
    int   lat[2];
    bit   err_seen[2];

    // ---------------- model: access -> expected cycle list ----------------
    rec_t bq[$];
    bit   b_rd, b_wr, b_h, b_d;
    int   b_hc, b_mc;

    task automatic push(input outs_t o, input bit ack, input bit clr, input bit req);
        rec_t r;
        r.o = o; r.rd = req && b_rd; r.wr = req && b_wr; r.h = b_h; r.d = b_d;
        r.ack = ack; r.clr = clr; r.hc = b_hc; r.mc = b_mc;
        bq.push_back(r);
    endtask

    task automatic mem_phase(input outs_t o, input int ack_at, input int tmo, output bit timed_out);
        if (ack_at >= 1 && (tmo == 0 || ack_at <= tmo)) begin
            for (int i = 1; i <= ack_at; i++) push(o, i == ack_at, 1'b0, 1'b0);
            timed_out = 1'b0;
        end else begin
            for (int i = 1; i <= tmo; i++) push(o, 1'b0, 1'b0, 1'b0);
            timed_out = 1'b1;
        end
    endtask

    task automatic build(input int inst, input bit rd, input bit wr, input bit h, input bit d,
                         input int ack_wb, input int ack_fill, input int ack_wt,
                         input bit clr, input bit ack_early);
        bit    wb, wa, op_wr, failed, need_fill, need_wrc, need_wt;
        int    tmo;
        outs_t o;
        wb  = (inst == 0);
        wa  = (inst == 0);
        tmo = (inst == 0) ? 255 : 4;
        bq.delete();
        b_rd = rd; b_wr = wr; b_h = h; b_d = d;
        b_hc = m_hit[inst]; b_mc = m_miss[inst];
        op_wr = wr && !rd;
        push('0, 1'b0, 1'b0, 1'b1);
        o = '0; o.busy = 1'b1;
        push(o, ack_early, clr, 1'b0);
        if (clr)    begin b_hc = 0; b_mc = 0; end
        else if (h) b_hc = (b_hc == CNT_MAX) ? b_hc : b_hc + 1;
        else        b_mc = (b_mc == CNT_MAX) ? b_mc : b_mc + 1;
        failed = 1'b0; need_fill = 1'b0; need_wrc = 1'b0; need_wt = 1'b0;
        if (h) begin
            need_wrc = op_wr;
        end else if (!op_wr || wa) begin
            if (wb && d) begin
                o = '0; o.busy = 1'b1; o.mem_write = 1'b1; o.mem_victim = 1'b1;
                mem_phase(o, ack_wb, tmo, failed);
            end
            need_fill = !failed;
        end else begin
            need_wt = 1'b1;
        end
        if (need_fill) begin
            o = '0; o.busy = 1'b1; o.mem_read = 1'b1;
            mem_phase(o, ack_fill, tmo, failed);
            if (!failed) begin
                o = '0; o.busy = 1'b1; o.update_tag = 1'b1; o.fill_we = 1'b1; o.clr_dirty = 1'b1;
                push(o, 1'b0, 1'b0, 1'b0);
                need_wrc = op_wr;
            end
        end
        if (need_wrc) begin
            o = '0; o.busy = 1'b1; o.cache_we = 1'b1; o.set_dirty = wb;
            push(o, 1'b0, 1'b0, 1'b0);
            need_wt = !wb;
        end
        if (need_wt) begin
            o = '0; o.busy = 1'b1; o.mem_write = 1'b1;
            mem_phase(o, ack_wt, tmo, failed);
        end
        o = '0; o.busy = 1'b1; o.ready = 1'b1; o.error = failed;
        push(o, 1'b0, 1'b0, 1'b0);
        m_hit[inst] = b_hc; m_miss[inst] = b_mc;
        foreach (bq[i]) begin
            if (inst == 0) qa.push_back(bq[i]);
            else           qb.push_back(bq[i]);
        end
    endtask

    function automatic rec_t idle_rec(input int inst);
        rec_t r;
        r.o = '0; r.rd = 1'b0; r.wr = 1'b0; r.h = 1'b0; r.d = 1'b0;
        r.ack = 1'b0; r.clr = 1'b0; r.hc = m_hit[inst]; r.mc = m_miss[inst];
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input int inst);
        rec_t r;
        bit   rst;
        rst = (inst == 0) ? reset_a : reset_b;
        if (rst) begin
            if (inst == 0) qa.delete(); else qb.delete();
            r = idle_rec(inst);
        end else if (inst == 0 && qa.size() > 0) begin
            r = qa.pop_front();
        end else if (inst == 1 && qb.size() > 0) begin
            r = qb.pop_front();
        end else begin
            r = idle_rec(inst);
        end
        cur[inst] = r;
        if (r.rd || r.wr) req_cyc[inst] = cyc;
        if (inst == 0) begin
            rd_a = r.rd; wr_a = r.wr; hit_a = r.h; dirty_a = r.d; ack_a = r.ack; clr_a = r.clr;
        end else begin
            rd_b = r.rd; wr_b = r.wr; hit_b = r.h; dirty_b = r.d; ack_b = r.ack; clr_b = r.clr;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        drive(0);
        drive(1);
    end

    // ---------------- compare ----------------
    task automatic cmp(input int inst);
        outs_t got, exp;
        int    gh, gm, eh, em;
        bit    rst;
        if (inst == 0) begin
            rst = reset_a;
            got = {o_ready_a, o_error_a, o_busy_a, o_update_tag_a, o_fill_we_a, o_cache_we_a,
                   o_set_dirty_a, o_clr_dirty_a, o_mem_read_a, o_mem_write_a, o_mem_victim_a};
            gh = int'(hit_cnt_a); gm = int'(miss_cnt_a);
        end else begin
            rst = reset_b;
            got = {o_ready_b, o_error_b, o_busy_b, o_update_tag_b, o_fill_we_b, o_cache_we_b,
                   o_set_dirty_b, o_clr_dirty_b, o_mem_read_b, o_mem_write_b, o_mem_victim_b};
            gh = int'(hit_cnt_b); gm = int'(miss_cnt_b);
        end
        exp = rst ? outs_t'(0) : cur[inst].o;
        eh  = rst ? 0 : cur[inst].hc;
        em  = rst ? 0 : cur[inst].mc;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL outputs inst=%0d cyc=%0d got=%b exp=%b (rdy,err,busy,tag,fill,cwe,sd,cd,mr,mw,mv)",
                     inst, cyc, got, exp);
        end
        checks++;
        if (gh != eh || gm != em) begin
            errors++;
            $display("FAIL counters inst=%0d cyc=%0d got hit=%0d miss=%0d exp hit=%0d miss=%0d",
                     inst, cyc, gh, gm, eh, em);
        end
        if (!rst && got.ready) begin
            lat[inst]      = cyc - req_cyc[inst];
            err_seen[inst] = got.error;
        end
    endtask

    always @(negedge clk) begin
        cmp(0);
        cmp(1);
    end

    task automatic check_lit(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic wait_idle(input int inst);
        int n;
        n = 0;
        while (((inst == 0) ? qa.size() : qb.size()) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL wait_idle inst=%0d got=timeout exp=drained", inst);
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        m_hit = '{0, 0}; m_miss = '{0, 0};
        req_cyc = '{0, 0}; lat = '{0, 0}; err_seen = '{1'b0, 1'b0};
        cur[0] = idle_rec(0); cur[1] = idle_rec(1);
        rd_a = 0; wr_a = 0; hit_a = 0; dirty_a = 0; ack_a = 0; clr_a = 0;
        rd_b = 0; wr_b = 0; hit_b = 0; dirty_b = 0; ack_b = 0; clr_b = 0;
        repeat (3) @(posedge clk);
        #2 reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);
        check_lit("rst_busy_a", int'(o_busy_a), 0);

        // A: read hit
        build(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        check_lit("model_len_rd_hit", qa.size(), 3);
        wait_idle(0);
        check_lit("lat_rd_hit", lat[0], 2);
        check_lit("hit_cnt_rd_hit", int'(hit_cnt_a), 1);

        // A: read miss, dirty victim, WB ack on 3rd cycle, fill ack on 2nd
        build(0, 1, 0, 0, 1, 3, 2, 0, 0, 0);
        check_lit("model_len_dirty_miss", qa.size(), 9);
        wait_idle(0);
        check_lit("lat_dirty_miss", lat[0], 8);
        check_lit("miss_cnt_dirty_miss", int'(miss_cnt_a), 1);

        // A: write hit (write-back)
        build(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        wait_idle(0);
        check_lit("lat_wr_hit_wb", lat[0], 3);

        // A: clean read miss, stray ack in LOOKUP, fill ack on first cycle
        build(0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        wait_idle(0);
        check_lit("lat_clean_miss", lat[0], 4);

        // A: read and write together -> read path
        build(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        wait_idle(0);
        check_lit("lat_rd_wr_both", lat[0], 2);

        // A: write miss with allocate
        build(0, 0, 1, 0, 0, 0, 2, 0, 0, 0);
        wait_idle(0);
        check_lit("lat_wr_miss_alloc", lat[0], 6);

        // A: saturate hit counter (3 hits so far + 5)
        for (int i = 0; i < 5; i++) build(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        wait_idle(0);
        check_lit("hit_cnt_sat", int'(hit_cnt_a), 7);
        check_lit("miss_cnt_before_clr", int'(miss_cnt_a), 3);

        // A: stats_clr during a hitting LOOKUP
        build(0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        wait_idle(0);
        check_lit("hit_cnt_clr", int'(hit_cnt_a), 0);
        check_lit("miss_cnt_clr", int'(miss_cnt_a), 0);

        // A: reset asserted while in FILL
        build(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #2 reset_a = 1'b1;
        m_hit[0] = 0; m_miss[0] = 0;
        @(negedge clk);
        check_lit("rst_in_fill_mem_read", int'(o_mem_read_a), 0);
        check_lit("rst_in_fill_busy", int'(o_busy_a), 0);
        repeat (2) @(posedge clk);
        #2 reset_a = 1'b0;
        @(negedge clk);
        build(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        wait_idle(0);
        check_lit("hit_cnt_after_rst", int'(hit_cnt_a), 1);

        // B: write hit, write-through, WT ack on 2nd cycle
        build(1, 0, 1, 1, 0, 0, 0, 2, 0, 0);
        wait_idle(1);
        check_lit("lat_wr_hit_wt", lat[1], 5);

        // B: write miss without allocate
        build(1, 0, 1, 0, 1, 0, 0, 3, 0, 0);
        wait_idle(1);
        check_lit("lat_wr_miss_noalloc", lat[1], 5);

        // B: read miss, no ack -> timeout after 4 cycles
        build(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_lit("model_len_timeout", qb.size(), 7);
        wait_idle(1);
        check_lit("lat_timeout", lat[1], 6);
        check_lit("err_timeout", int'(err_seen[1]), 1);

        // B: ack on the timeout cycle wins; dirty ignored without write-back
        build(1, 1, 0, 0, 1, 0, 4, 0, 0, 0);
        wait_idle(1);
        check_lit("lat_ack_at_timeout", lat[1], 7);
        check_lit("err_ack_at_timeout", int'(err_seen[1]), 0);

        // B: write hit, WT never acked
        build(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        wait_idle(1);
        check_lit("lat_wt_timeout", lat[1], 7);
        check_lit("err_wt_timeout", int'(err_seen[1]), 1);
        check_lit("hit_cnt_b", int'(hit_cnt_b), 2);
        check_lit("miss_cnt_b", int'(miss_cnt_b), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
